// File: rtl/load_store_unit.sv
// Load/store stage: turns one core memory op into a req/gnt/rvalid transaction with
// byte enables, lane-replicated store data, extended load data and error flags.
module load_store_unit #(
    parameter int unsigned ADDRESS_BITS   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_BITS-1:0] req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_misalign,
    output logic                    resp_timeout,
    output logic                    stall,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [3:0]              mem_be,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]              state_q;
    logic                    wen_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    misalign_q;
    logic                    timeout_q;
    logic [7:0]              count_q;

    logic                    misalign_in;
    logic [3:0]              be_lane;
    logic [31:0]             wdata_lane;
    logic [31:0]             rdata_shift;
    logic [31:0]             load_ext;
    logic                    in_req;
    logic                    in_resp;

    always_comb begin
        misalign_in = 1'b0;
        case (req_size)
            2'b01:   misalign_in = req_addr[0];
            2'b10:   misalign_in = (req_addr[1:0] != 2'b00);
            2'b11:   misalign_in = 1'b1;
            default: misalign_in = 1'b0;
        endcase
    end

    always_comb begin
        be_lane     = 4'b1111;
        wdata_lane  = wdata_q;
        rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext    = rdata_shift;
        case (size_q)
            2'b00: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
                load_ext   = unsigned_q ? {24'h0, rdata_shift[7:0]}
                                        : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            end
            2'b01: begin
                be_lane    = 4'b0011 << addr_q[1:0];
                wdata_lane = {2{wdata_q[15:0]}};
                load_ext   = unsigned_q ? {16'h0, rdata_shift[15:0]}
                                        : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = wdata_q;
                load_ext   = rdata_shift;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wen_q      <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q      <= req_wen;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rdata_q    <= '0;
                        misalign_q <= misalign_in;
                        timeout_q  <= 1'b0;
                        count_q    <= '0;
                        state_q    <= misalign_in ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        count_q <= '0;
                        state_q <= wen_q ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // rvalid takes priority over a timeout landing in the same cycle
                    if (mem_rvalid) begin
                        rdata_q <= load_ext;
                        state_q <= ST_RESP;
                    end else if (count_q == COUNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_req  = (state_q == ST_REQ);
    assign in_resp = (state_q == ST_RESP);

    assign req_ready     = (state_q == ST_IDLE);
    assign stall         = (state_q != ST_IDLE);
    assign mem_req       = in_req;
    assign mem_we        = in_req & wen_q;
    assign mem_be        = in_req ? be_lane : 4'b0000;
    assign mem_addr      = in_req ? {addr_q[ADDRESS_BITS-1:2], 2'b00} : '0;
    assign mem_wdata     = in_req ? wdata_lane : '0;
    assign resp_valid    = in_resp;
    assign resp_rdata    = in_resp ? rdata_q : '0;
    assign resp_misalign = in_resp & misalign_q;
    assign resp_timeout  = in_resp & timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: a negedge monitor pops a response scoreboard,
// scenario tasks drive the memory side and check request-side timing inline.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_misalign, resp_timeout, stall;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   resp_count = 0;

    load_store_unit #(.ADDRESS_BITS(16), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_timeout(resp_timeout), .stall(stall),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset === 1'b1 && resp_valid === 1'b1) begin
            exp_t e;
            resp_count++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid=1 rdata=%h, no response expected", resp_rdata);
            end else begin
                e = sb.pop_front();
                if (resp_rdata !== e.rdata || resp_misalign !== e.mis || resp_timeout !== e.tmo) begin
                    n_fail++;
                    $display("FAIL resp_payload: got rdata=%h mis=%b tmo=%b, expected rdata=%h mis=%b tmo=%b",
                             resp_rdata, resp_misalign, resp_timeout, e.rdata, e.mis, e.tmo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic wen, input logic [1:0] sz, input logic uns,
                         input logic [15:0] a, input logic [31:0] d);
        req_wen = wen; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0 ||
            mem_be !== 4'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_misalign !== 1'b0 || resp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b stall=%b req=%b rv=%b be=%b, expected ready=1 others 0",
                     req_ready, stall, mem_req, resp_valid, mem_be);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic load_op(input string name, input logic [15:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rd, input logic [31:0] exp_d,
                           input logic [3:0] exp_be);
        offer(1'b0, sz, uns, a, 32'h0);
        mem_gnt = 1'b1;
        sb.push_back(exp_t'{rdata: exp_d, mis: 1'b0, tmo: 1'b0});
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== exp_be || mem_addr !== {a[15:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s_req: req=%b we=%b be=%b addr=%h, expected 1 0 %b %h",
                     name, mem_req, mem_we, mem_be, mem_addr, exp_be, {a[15:2], 2'b00});
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: resp_valid=%b at T+3, expected 1", name, resp_valid);
        end
        tick();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pulse: resp_valid=%b ready=%b, expected 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_loads();
        load_op("lw",  16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        load_op("lb",  16'h0013, 2'b00, 1'b0, 32'h80FF0000, 32'hFFFFFF80, 4'b1000);
        load_op("lbu", 16'h0013, 2'b00, 1'b1, 32'h80FF0000, 32'h00000080, 4'b1000);
        load_op("lh",  16'h0002, 2'b01, 1'b0, 32'h9ABC0000, 32'hFFFF9ABC, 4'b1100);
        load_op("lhu", 16'h0002, 2'b01, 1'b1, 32'h9ABC0000, 32'h00009ABC, 4'b1100);
    endtask

    task automatic test_store_delayed_gnt();
        offer(1'b1, 2'b01, 1'b0, 16'h0022, 32'h00001234);
        sb.push_back(exp_t'{rdata: 32'h0, mis: 1'b0, tmo: 1'b0});
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_gnt = 1'b1;
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'h12341234 || mem_addr !== 16'h0020 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sh_hold%0d: req=%b we=%b be=%b wdata=%h addr=%h rv=%b, expected 1 1 1100 12341234 0020 0",
                         i, mem_req, mem_we, mem_be, mem_wdata, mem_addr, resp_valid);
            end
            tick();
        end
        mem_gnt = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_resp: resp_valid=%b mem_req=%b after gnt, expected 1 0", resp_valid, mem_req);
        end
        tick();
    endtask

    task automatic test_misalign();
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        logic [15:0] addrs [3] = '{16'h0005, 16'h0011, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF);
            mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
            sb.push_back(exp_t'{rdata: 32'h0, mis: 1'b1, tmo: 1'b0});
            tick();
            req_valid = 1'b0;
            n_checks++;
            if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign%0d_T1: resp_valid=%b mem_req=%b, expected 1 0", i, resp_valid, mem_req);
            end
            tick();
            mem_rvalid = 1'b0;
            n_checks++;
            if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL misalign%0d_after: mem_req=%b ready=%b, expected 0 1", i, mem_req, req_ready);
            end
        end
    endtask

    task automatic test_timeout(input logic rv_last);
        offer(1'b0, 2'b10, 1'b0, 16'h0044, 32'h0);
        mem_gnt = 1'b1;
        sb.push_back(exp_t'{rdata: rv_last ? 32'h12345678 : 32'h0, mis: 1'b0, tmo: ~rv_last});
        tick();
        req_valid = 1'b0;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && rv_last) begin mem_rvalid = 1'b1; mem_rdata = 32'h12345678; end
            n_checks++;
            if (resp_valid !== 1'b0 || stall !== 1'b1) begin
                n_fail++;
                $display("FAIL wait%0d_rv%0b: resp_valid=%b stall=%b, expected 0 1", i, rv_last, resp_valid, stall);
            end
            tick();
        end
        mem_rvalid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rv%0b: resp_valid=%b after 4 WAIT cycles, expected 1", rv_last, resp_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        offer(1'b0, 2'b10, 1'b0, 16'h0080, 32'h0);
        mem_gnt = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        mem_gnt = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b stall=%b req=%b rv=%b, expected 1 0 0 0",
                     req_ready, stall, mem_req, resp_valid);
        end
        tick();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        tick();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL late_rvalid: rv=%b ready=%b stall=%b, expected 0 1 0", resp_valid, req_ready, stall);
        end
    endtask

    task automatic test_back_to_back();
        int target;
        target = resp_count + 3;
        for (int i = 0; i < 3; i++) sb.push_back(exp_t'{rdata: 32'h0, mis: 1'b0, tmo: 1'b0});
        offer(1'b1, 2'b00, 1'b0, 16'h0001, 32'h000000AB);
        mem_gnt = 1'b1;
        for (int i = 0; i < 20 && resp_count < target; i++) begin
            if (mem_req === 1'b1) begin
                n_checks++;
                if (mem_be !== 4'b0010 || mem_wdata !== 32'hABABABAB || mem_addr !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL b2b_lane: be=%b wdata=%h addr=%h, expected 0010 ABABABAB 0000",
                             mem_be, mem_wdata, mem_addr);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        mem_gnt = 1'b0;
        tick(); tick();
        n_checks++;
        if (resp_count !== target || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: responses=%0d stall=%b, expected %0d 0", resp_count, stall, target);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_delayed_gnt();
        test_misalign();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_back_to_back();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
